alu_rs: RTL and testbench

Reservation station feeding the integer ALU. Holds up to `RS_SIZE` decoded ALU/branch micro-ops with their operands or producer ROB tags. It snoops two result broadcast buses (ALU and load/store buffer) to wake operands. Each cycle it dispatches at most one fully-ready entry to the ALU through the ALU's `valid`/operand inputs.

---
 rtl/alu_rs_pkg.sv | 45 ++++
 rtl/alu_rs_select.sv | 25 ++
 rtl/alu_rs.sv | 187 ++++++++++++++++++
 tb/tb_alu_rs.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared constants for the ALU reservation station: ROB tag width, RV32I opcodes,
// funct3 encodings and the station entry layout.
package alu_rs_pkg;

  localparam int unsigned ROB_BIT = 4;

  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] B_TYPE = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic               busy;
    logic [2:0]         op;
    logic [6:0]         op_type;
    logic               op_addition;
    logic [31:0]        vj;
    logic [31:0]        vk;
    logic               qj_busy;
    logic               qk_busy;
    logic [ROB_BIT-1:0] qj;
    logic [ROB_BIT-1:0] qk;
    logic [ROB_BIT-1:0] rob;
  } rs_entry_t;

  function automatic logic is_alu_op_type(input logic [6:0] t);
    return (t == I_TYPE) || (t == R_TYPE) || (t == B_TYPE);
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Lowest-index priority encoder: returns the index of the lowest set request bit
// and whether any bit was set.
module rs_select #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         i_req,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_found
);

  localparam int unsigned IW = $clog2(N);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_req[N-1-i]) begin
        o_idx   = IW'(N - 1 - i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds decoded micro-ops, wakes operands
// from the ALU and LSB broadcast buses, and dispatches one ready entry per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned RS_SIZE = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic               rob_clear_up,

  input  logic               issue_valid,
  input  logic [2:0]         issue_op,
  input  logic [6:0]         issue_op_type,
  input  logic               issue_op_addition,
  input  logic [31:0]        issue_vj,
  input  logic [31:0]        issue_vk,
  input  logic               issue_qj_busy,
  input  logic               issue_qk_busy,
  input  logic [ROB_BIT-1:0] issue_qj,
  input  logic [ROB_BIT-1:0] issue_qk,
  input  logic [ROB_BIT-1:0] issue_rob_entry,
  output logic               full,

  input  logic               alu_cdb_ready,
  input  logic [ROB_BIT-1:0] alu_cdb_rob,
  input  logic [31:0]        alu_cdb_res,
  input  logic               lsb_cdb_ready,
  input  logic [ROB_BIT-1:0] lsb_cdb_rob,
  input  logic [31:0]        lsb_cdb_res,

  output logic               valid,
  output logic [31:0]        vi,
  output logic [31:0]        vj,
  output logic [2:0]         op,
  output logic [6:0]         op_type,
  output logic               op_addition,
  output logic [ROB_BIT-1:0] rob_entry
);

  localparam int unsigned IW = $clog2(RS_SIZE);

  rs_entry_t r_ent [RS_SIZE];

  logic [RS_SIZE-1:0] w_busy;
  logic [RS_SIZE-1:0] w_ready;
  logic [IW-1:0]      w_free_idx;
  logic [IW-1:0]      w_disp_idx;
  logic               w_free_found;
  logic               w_disp_found;
  logic               w_issue_ok;
  logic [31:0]        w_vj;
  logic [31:0]        w_vk;
  logic               w_qj_busy;
  logic               w_qk_busy;

  always_comb begin
    w_busy  = '0;
    w_ready = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      w_busy[i]  = r_ent[i].busy;
      w_ready[i] = r_ent[i].busy && !r_ent[i].qj_busy && !r_ent[i].qk_busy;
    end
  end

  assign full       = &w_busy;
  assign w_issue_ok = issue_valid && w_free_found;

  rs_select #(.N(RS_SIZE)) u_free_sel (
    .i_req   (~w_busy),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  rs_select #(.N(RS_SIZE)) u_disp_sel (
    .i_req   (w_ready),
    .o_idx   (w_disp_idx),
    .o_found (w_disp_found)
  );

  // Operands whose producer broadcasts in the issue cycle are captured directly; ALU bus first.
  always_comb begin
    w_vj      = issue_vj;
    w_qj_busy = issue_qj_busy;
    if (issue_qj_busy && alu_cdb_ready && (alu_cdb_rob == issue_qj)) begin
      w_vj      = alu_cdb_res;
      w_qj_busy = 1'b0;
    end else if (issue_qj_busy && lsb_cdb_ready && (lsb_cdb_rob == issue_qj)) begin
      w_vj      = lsb_cdb_res;
      w_qj_busy = 1'b0;
    end
    w_vk      = issue_vk;
    w_qk_busy = issue_qk_busy;
    if (issue_qk_busy && alu_cdb_ready && (alu_cdb_rob == issue_qk)) begin
      w_vk      = alu_cdb_res;
      w_qk_busy = 1'b0;
    end else if (issue_qk_busy && lsb_cdb_ready && (lsb_cdb_rob == issue_qk)) begin
      w_vk      = lsb_cdb_res;
      w_qk_busy = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
      valid       <= 1'b0;
      vi          <= '0;
      vj          <= '0;
      op          <= '0;
      op_type     <= '0;
      op_addition <= 1'b0;
      rob_entry   <= '0;
    end else if (rob_clear_up) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) r_ent[i].busy <= 1'b0;
      valid       <= 1'b0;
      vi          <= '0;
      vj          <= '0;
      op          <= '0;
      op_type     <= '0;
      op_addition <= 1'b0;
      rob_entry   <= '0;
    end else if (rdy_in) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (r_ent[i].busy && r_ent[i].qj_busy) begin
          if (alu_cdb_ready && (alu_cdb_rob == r_ent[i].qj)) begin
            r_ent[i].vj      <= alu_cdb_res;
            r_ent[i].qj_busy <= 1'b0;
          end else if (lsb_cdb_ready && (lsb_cdb_rob == r_ent[i].qj)) begin
            r_ent[i].vj      <= lsb_cdb_res;
            r_ent[i].qj_busy <= 1'b0;
          end
        end
        if (r_ent[i].busy && r_ent[i].qk_busy) begin
          if (alu_cdb_ready && (alu_cdb_rob == r_ent[i].qk)) begin
            r_ent[i].vk      <= alu_cdb_res;
            r_ent[i].qk_busy <= 1'b0;
          end else if (lsb_cdb_ready && (lsb_cdb_rob == r_ent[i].qk)) begin
            r_ent[i].vk      <= lsb_cdb_res;
            r_ent[i].qk_busy <= 1'b0;
          end
        end
      end

      if (w_disp_found) begin
        valid                 <= 1'b1;
        vi                    <= r_ent[w_disp_idx].vj;
        vj                    <= r_ent[w_disp_idx].vk;
        op                    <= r_ent[w_disp_idx].op;
        op_type               <= r_ent[w_disp_idx].op_type;
        op_addition           <= r_ent[w_disp_idx].op_addition;
        rob_entry             <= r_ent[w_disp_idx].rob;
        r_ent[w_disp_idx].busy <= 1'b0;
      end else begin
        valid <= 1'b0;
      end

      // The free slot is never the dispatched one: dispatch needs busy, free needs !busy.
      if (w_issue_ok) begin
        r_ent[w_free_idx] <= '{busy:        1'b1,
                               op:          issue_op,
                               op_type:     issue_op_type,
                               op_addition: issue_op_addition,
                               vj:          w_vj,
                               vk:          w_vk,
                               qj_busy:     w_qj_busy,
                               qk_busy:     w_qk_busy,
                               qj:          issue_qj,
                               qk:          issue_qk,
                               rob:         issue_rob_entry};
      end
    end
  end

  a_issue_not_full: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (rdy_in && !rob_clear_up && issue_valid) |-> !full)
    else $warning("alu_rs: issue dropped while station full");

  a_cdb_unique: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(alu_cdb_ready && lsb_cdb_ready && (alu_cdb_rob == lsb_cdb_rob)))
    else $error("alu_rs: both broadcast buses carry the same ROB tag");

  a_op_type: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (rdy_in && !rob_clear_up && w_issue_ok) |-> is_alu_op_type(issue_op_type))
    else $fatal(1, "alu_rs: unsupported opcode %b", issue_op_type);

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed issues push expected dispatches; a negedge
// monitor pops and compares on every valid pulse.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic               clk_in, rst_n_in, rdy_in, rob_clear_up;
  logic               issue_valid, issue_op_addition, issue_qj_busy, issue_qk_busy;
  logic [2:0]         issue_op;
  logic [6:0]         issue_op_type;
  logic [31:0]        issue_vj, issue_vk;
  logic [ROB_BIT-1:0] issue_qj, issue_qk, issue_rob_entry;
  logic               full;
  logic               alu_cdb_ready, lsb_cdb_ready;
  logic [ROB_BIT-1:0] alu_cdb_rob, lsb_cdb_rob;
  logic [31:0]        alu_cdb_res, lsb_cdb_res;
  logic               valid, op_addition;
  logic [31:0]        vi, vj;
  logic [2:0]         op;
  logic [6:0]         op_type;
  logic [ROB_BIT-1:0] rob_entry;

  alu_rs #(.RS_SIZE(8)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_op_type(issue_op_type),
    .issue_op_addition(issue_op_addition), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_rob_entry(issue_rob_entry),
    .full(full),
    .alu_cdb_ready(alu_cdb_ready), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_res(alu_cdb_res),
    .lsb_cdb_ready(lsb_cdb_ready), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_res(lsb_cdb_res),
    .valid(valid), .vi(vi), .vj(vj), .op(op), .op_type(op_type),
    .op_addition(op_addition), .rob_entry(rob_entry)
  );

  typedef struct {
    logic [31:0]        vi;
    logic [31:0]        vj;
    logic [2:0]         op;
    logic [6:0]         op_type;
    logic               add;
    logic [ROB_BIT-1:0] rob;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                      input logic [6:0] ot, input logic add, input logic [ROB_BIT-1:0] rob);
    exp_t e;
    e.vi = a; e.vj = b; e.op = f3; e.op_type = ot; e.add = add; e.rob = rob;
    exp_q.push_back(e);
  endtask

  task automatic do_issue(input logic [2:0] f3, input logic [6:0] ot, input logic add,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic qjb, input logic [ROB_BIT-1:0] qj,
                          input logic qkb, input logic [ROB_BIT-1:0] qk,
                          input logic [ROB_BIT-1:0] rob);
    issue_op = f3; issue_op_type = ot; issue_op_addition = add;
    issue_vj = a; issue_vk = b;
    issue_qj_busy = qjb; issue_qj = qj; issue_qk_busy = qkb; issue_qk = qk;
    issue_rob_entry = rob;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  // Monitor: every dispatch pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in && valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_dispatch: got rob %0d vi %h, required no dispatch", rob_entry, vi);
        end else begin
          e = exp_q.pop_front();
          if (vi !== e.vi || vj !== e.vj || op !== e.op || op_type !== e.op_type ||
              op_addition !== e.add || rob_entry !== e.rob) begin
            n_err++;
            $display("FAIL dispatch: got vi=%h vj=%h op=%b type=%b add=%b rob=%0d, required vi=%h vj=%h op=%b type=%b add=%b rob=%0d",
                     vi, vj, op, op_type, op_addition, rob_entry,
                     e.vi, e.vj, e.op, e.op_type, e.add, e.rob);
          end
        end
      end
    end
  end

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; rob_clear_up = 1'b0;
    issue_valid = 1'b0; issue_op = '0; issue_op_type = R_TYPE; issue_op_addition = 1'b0;
    issue_vj = '0; issue_vk = '0; issue_qj_busy = 1'b0; issue_qk_busy = 1'b0;
    issue_qj = '0; issue_qk = '0; issue_rob_entry = '0;
    alu_cdb_ready = 1'b0; alu_cdb_rob = '0; alu_cdb_res = '0;
    lsb_cdb_ready = 1'b0; lsb_cdb_rob = '0; lsb_cdb_res = '0;

    #12;
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_vi", vi, 32'd0);
    chk("reset_rob", {28'd0, rob_entry}, 32'd0);
    rst_n_in = 1'b1;
    tick();

    // Independent ADD
    push(32'd5, 32'd7, F3_ADD_SUB, R_TYPE, 1'b0, 4'd3);
    do_issue(F3_ADD_SUB, R_TYPE, 1'b0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    repeat (3) tick();

    // qj waits on rob 2, woken by LSB bus
    push(32'h10, 32'd1, F3_ADD_SUB, I_TYPE, 1'b0, 4'd5);
    do_issue(F3_ADD_SUB, I_TYPE, 1'b0, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
    repeat (2) tick();
    chk("wait_no_early_valid", {31'd0, valid}, 32'd0);
    lsb_cdb_ready = 1'b1; lsb_cdb_rob = 4'd2; lsb_cdb_res = 32'h10;
    tick();
    lsb_cdb_ready = 1'b0;
    repeat (3) tick();

    // qk captured from ALU bus in the issue cycle (SUB)
    push(32'd3, 32'd9, F3_ADD_SUB, R_TYPE, 1'b1, 4'd6);
    alu_cdb_ready = 1'b1; alu_cdb_rob = 4'd4; alu_cdb_res = 32'd9;
    do_issue(F3_ADD_SUB, R_TYPE, 1'b1, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd6);
    alu_cdb_ready = 1'b0;
    repeat (3) tick();

    // Fill all 8 entries, drop a 9th, wake entry 3
    for (int i = 0; i < 8; i++)
      do_issue(F3_ADD_SUB, R_TYPE, 1'b0, 32'd0, 32'h100 + i, 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(i));
    chk("full_after_fill", {31'd0, full}, 32'd1);
    do_issue(F3_OR, R_TYPE, 1'b0, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    chk("full_after_drop", {31'd0, full}, 32'd1);
    push(32'h33, 32'h103, F3_ADD_SUB, R_TYPE, 1'b0, 4'd3);
    lsb_cdb_ready = 1'b1; lsb_cdb_rob = 4'd11; lsb_cdb_res = 32'h33;
    tick();
    lsb_cdb_ready = 1'b0;
    chk("full_at_wakeup", {31'd0, full}, 32'd1);
    tick();
    chk("full_after_dispatch", {31'd0, full}, 32'd0);
    tick();
    rob_clear_up = 1'b1;
    tick();
    rob_clear_up = 1'b0;
    chk("full_after_clear1", {31'd0, full}, 32'd0);

    // Flush 5 busy entries, the last one ready to dispatch on the flush edge
    for (int i = 0; i < 4; i++)
      do_issue(F3_XOR, R_TYPE, 1'b0, 32'd0, 32'd0, 1'b1, 4'(i), 1'b0, 4'd0, 4'(10 + i));
    do_issue(F3_XOR, R_TYPE, 1'b0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14);
    rob_clear_up = 1'b1;
    tick();
    rob_clear_up = 1'b0;
    chk("flush_full", {31'd0, full}, 32'd0);
    chk("flush_valid", {31'd0, valid}, 32'd0);
    for (int t = 0; t < 4; t++) begin
      lsb_cdb_ready = 1'b1; lsb_cdb_rob = 4'(t); lsb_cdb_res = 32'hdead0000 + t;
      tick();
      chk("flushed_no_dispatch", {31'd0, valid}, 32'd0);
    end
    lsb_cdb_ready = 1'b0;
    tick();
    chk("flushed_no_dispatch_end", {31'd0, valid}, 32'd0);

    // Issue discarded by a simultaneous flush
    rob_clear_up = 1'b1;
    do_issue(F3_OR, R_TYPE, 1'b0, 32'd4, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13);
    rob_clear_up = 1'b0;
    tick();
    chk("clear_issue_valid", {31'd0, valid}, 32'd0);
    chk("clear_issue_full", {31'd0, full}, 32'd0);
    tick();

    // rdy_in low freezes a ready entry
    push(32'h21, 32'h22, F3_AND, R_TYPE, 1'b0, 4'd9);
    do_issue(F3_AND, R_TYPE, 1'b0, 32'h21, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_valid", {31'd0, valid}, 32'd0);
      chk("hold_vi", vi, 32'd0);
      chk("hold_rob", {28'd0, rob_entry}, 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    chk("release_valid", {31'd0, valid}, 32'd1);
    tick();
    chk("after_pulse_valid", {31'd0, valid}, 32'd0);
    chk("after_pulse_vi_hold", vi, 32'h21);

    // Asynchronous reset mid-cycle
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("async_vi", vi, 32'd0);
    chk("async_vj", vj, 32'd0);
    chk("async_op_type", {25'd0, op_type}, 32'd0);
    chk("async_rob", {28'd0, rob_entry}, 32'd0);
    chk("async_valid", {31'd0, valid}, 32'd0);
    #10;
    rst_n_in = 1'b1;
    repeat (3) tick();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
